shake_ctrl: RTL and testbench
=============================

# shake_ctrl

Sequencer for the SHAKE128/SHAKE256 core. Accepts a message as a stream of 64-bit words, drives the absorb/pad enables of the Keccak state lane registers, launches the permutation at each rate-block boundary, and then streams the requested number of output words. It holds no message data itself. It sits between the byte-stream front end, the state register file and the permutation round unit.

## Interface
Parameters:
- `OUT_LEN_W`, default 16: width of the output-length field.
- `RATE128`, default 21: rate in 64-bit lanes for SHAKE128.
- `RATE256`, default 17: rate in 64-bit lanes for SHAKE256.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  starts a job; sampled only in IDLE.
- `mode`  in  1  0 = SHAKE128, 1 = SHAKE256; latched on `start`.
- `out_len`  in  `OUT_LEN_W`  output words requested; latched on `start`.
- `in_valid` / `in_ready`  in / out  1  input word handshake.
- `in_last`  in  1  current input word is the final word.
- `in_bytes`  in  4  valid bytes in the last word, 0..8; ignored unless `in_last`.
- `state_clr`  out  1  zero all 25 lanes.
- `lane_idx`  out  5  lane addressed by absorb/pad/squeeze.
- `absorb_en`  out  1  XOR input word into lane `lane_idx`.
- `pad_head_en`  out  1  XOR 0x1F into byte `pad_byte` of `lane_idx`.
- `pad_byte`  out  3  byte position for the head pad.
- `pad_tail_en`  out  1  XOR 0x80 into byte 7 of `lane_idx`.
- `perm_start`  out  1  one-cycle permutation launch.
- `perm_done`  in  1  one-cycle permutation completion.
- `out_valid` / `out_ready`  out / in  1  squeeze handshake; data is lane `lane_idx`.
- `busy`  out  1  state != IDLE.
- `done`  out  1  one-cycle job completion pulse.

## Operation
- `rate` is `RATE128` if latched `mode` = 0, otherwise `RATE256`.
- Counters: `word_cnt` (5 b), `sq_cnt` (5 b), `out_cnt` (`OUT_LEN_W`).
- **IDLE:** On `start`, pulse `state_clr`, clear the counters, then go to ABSORB.
- **ABSORB:** `in_ready` = 1 and `lane_idx` = `word_cnt`. On a handshake:
  - Non-last word: `absorb_en` = 1. If `word_cnt` = rate-1, go to PERM with next = ABSORB and `word_cnt` := 0. Otherwise increment `word_cnt`.
  - Last word with `in_bytes` < 8: `absorb_en` = (`in_bytes` != 0), `pad_head_en` = 1, `pad_byte` = `in_bytes`. If `word_cnt` = rate-1, also assert `pad_tail_en` and go to PERM with next = SQUEEZE. Otherwise go to TAIL.
  - Last word with `in_bytes` = 8: `absorb_en` = 1. If `word_cnt` = rate-1, go to PERM with next = HEAD and `word_cnt` := 0. Otherwise increment `word_cnt` and go to HEAD.
- **HEAD:** One cycle. `pad_head_en` = 1, `pad_byte` = 0, `lane_idx` = `word_cnt`. Also assert `pad_tail_en` if `word_cnt` = rate-1 (byte becomes 0x9F). Then go to PERM with next = SQUEEZE if the tail was applied, otherwise go to TAIL.
- **TAIL:** One cycle. `pad_tail_en` = 1, `lane_idx` = rate-1. Then go to PERM with next = SQUEEZE.
- **PERM:** `perm_start` = 1 on the first cycle only. Wait for `perm_done`, then go to the stored next state.
- **SQUEEZE:** If `out_len` = 0, go directly to DONE. Otherwise `out_valid` = 1 and `lane_idx` = `sq_cnt`. On a handshake:
  - If `out_cnt` = `out_len`-1, go to DONE.
  - Else if `sq_cnt` = rate-1, go to PERM with next = SQUEEZE and `sq_cnt` := 0.
  - Otherwise increment `sq_cnt` and `out_cnt`.
- **DONE:** `done` = 1 for one cycle, then go to IDLE.
- `start` is ignored while busy. `perm_done` outside PERM is ignored.
- `absorb_en`, `pad_*_en` and `state_clr` are never asserted in the same cycle as `perm_start`.

## Timing
- Reset: state = IDLE. All outputs are 0 (`in_ready`, `out_valid`, `busy`, `done`, all enables, `lane_idx`, `pad_byte`). Counters are 0.
- Reset mid-job aborts immediately. The permutation unit is reset by the same `rst`.
- `in_ready`, `out_valid`, `perm_start`, `busy` and `done` are decoded from registered state only, with no input-to-output combinational path.
- `absorb_en` and `pad_*_en` in ABSORB are combinational in `in_valid`.
- Throughput: 1 word/cycle in ABSORB and SQUEEZE.
- Each permutation costs 1 + P cycles, where P is the latency from `perm_start` to `perm_done` (P ≥ 1).
- `start` to the first `in_ready`: 1 cycle (the `state_clr` cycle).

## Configuration
- `SHAKE_CTRL_ABORT_EN` defined: adds input `abort`.
  - In ABSORB, HEAD, TAIL or SQUEEZE: go to IDLE next cycle with no `done` pulse.
  - In PERM: go to ABORT_WAIT, hold until `perm_done`, then go to IDLE.
  - `abort` in IDLE or DONE is ignored.
- Undefined: no `abort` port and no ABORT_WAIT state.

## Test plan
- SHAKE128, empty message (`in_last`, `in_bytes`=0 at word 0), `out_len`=2:
  - Expect a head pad at lane 0 byte 0 with no absorb.
  - Then TAIL at lane 20, one `perm_start`, two output words on lanes 0 and 1, then `done`.
- SHAKE256, 16 full words with the 17th last and `in_bytes`=3: 17 absorbs, head and tail on lane 16 in the same cycle, one `perm_start`, then SQUEEZE.
- SHAKE128, exactly 21 full words with the last `in_bytes`=8: PERM after word 21, then HEAD at lane 0 byte 0, TAIL at lane 20, and 2 permutations total.
- SHAKE256, `out_len`=40 with `out_ready` toggling: 40 outputs, `lane_idx` wrapping 16→0, 2 extra squeeze permutations, `done` after word 40.
- `out_len`=0: `done` follows the final permutation with no `out_valid`. `start` asserted during busy is ignored.
- With `SHAKE_CTRL_ABORT_EN`:
  - `abort` in PERM holds the block in ABORT_WAIT until `perm_done`, then IDLE.
  - `abort` in SQUEEZE returns to IDLE next cycle with no `done`.

Source files
------------

// File: rtl/shake_ctrl.sv
// shake_ctrl: job sequencer for a SHAKE128/SHAKE256 core.
//
// Takes a message as a stream of 64-bit words, drives the absorb and pad
// enables of the Keccak lane register file, launches the permutation at each
// rate-block boundary and then streams the requested number of output lanes.
// No message data passes through this block.
//
// Parameters:
//   OUT_LEN_W  width of the output-length field
//   RATE128    rate in 64-bit lanes for SHAKE128
//   RATE256    rate in 64-bit lanes for SHAKE256
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   abort                    (SHAKE_CTRL_ABORT_EN only) cancel the running job
//   start, mode, out_len     job launch; mode/out_len latched on start in IDLE
//   in_valid/in_ready        input word handshake
//   in_last, in_bytes        final-word marker and its valid byte count (0..8)
//   state_clr                zero all 25 lanes
//   lane_idx                 lane addressed by absorb / pad / squeeze
//   absorb_en                XOR input word into lane_idx
//   pad_head_en, pad_byte    XOR 0x1F into byte pad_byte of lane_idx
//   pad_tail_en              XOR 0x80 into byte 7 of lane_idx
//   perm_start, perm_done    permutation launch / completion pulses
//   out_valid/out_ready      squeeze handshake, data is lane lane_idx
//   busy, done               job in progress / one-cycle completion pulse
//
// Optional feature: define SHAKE_CTRL_ABORT_EN to add the abort input and the
// ABORT_WAIT state that drains an in-flight permutation before going idle.

module shake_ctrl #(
  parameter int OUT_LEN_W = 16,
  parameter int RATE128   = 21,
  parameter int RATE256   = 17
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef SHAKE_CTRL_ABORT_EN
  input  logic                 abort,
`endif
  input  logic                 start,
  input  logic                 mode,
  input  logic [OUT_LEN_W-1:0] out_len,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_last,
  input  logic [3:0]           in_bytes,
  output logic                 state_clr,
  output logic [4:0]           lane_idx,
  output logic                 absorb_en,
  output logic                 pad_head_en,
  output logic [2:0]           pad_byte,
  output logic                 pad_tail_en,
  output logic                 perm_start,
  input  logic                 perm_done,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 done
);

`ifdef SHAKE_CTRL_ABORT_EN
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ABSORB     = 3'd1,
    ST_HEAD       = 3'd2,
    ST_TAIL       = 3'd3,
    ST_PERM       = 3'd4,
    ST_SQUEEZE    = 3'd5,
    ST_DONE       = 3'd6,
    ST_ABORT_WAIT = 3'd7
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ABSORB  = 3'd1,
    ST_HEAD    = 3'd2,
    ST_TAIL    = 3'd3,
    ST_PERM    = 3'd4,
    ST_SQUEEZE = 3'd5,
    ST_DONE    = 3'd6
  } state_t;
`endif

  state_t                 state_r, state_nx_s;
  state_t                 ret_r, ret_nx_s;        // where PERM resumes
  logic [4:0]             word_cnt_r, word_cnt_nx_s;
  logic [4:0]             sq_cnt_r, sq_cnt_nx_s;
  logic [OUT_LEN_W-1:0]   out_cnt_r, out_cnt_nx_s;
  logic                   mode_r;
  logic [OUT_LEN_W-1:0]   out_len_r;
  // High on every PERM cycle after the launch cycle, so perm_start is a
  // single pulse and a stray perm_done in the launch cycle is not taken.
  logic                   perm_issued_r;
  logic [4:0]             rate_m1_s;
  logic                   word_last_s;
  logic                   sq_last_s;
  logic                   out_last_s;

  assign rate_m1_s   = mode_r ? 5'(RATE256 - 1) : 5'(RATE128 - 1);
  assign word_last_s = (word_cnt_r == rate_m1_s);
  assign sq_last_s   = (sq_cnt_r == rate_m1_s);
  assign out_last_s  = (out_cnt_r == (out_len_r - {{(OUT_LEN_W-1){1'b0}}, 1'b1}));

  // Next-state, counter updates and output decode.
  always_comb begin
    state_nx_s    = state_r;
    ret_nx_s      = ret_r;
    word_cnt_nx_s = word_cnt_r;
    sq_cnt_nx_s   = sq_cnt_r;
    out_cnt_nx_s  = out_cnt_r;
    in_ready      = 1'b0;
    out_valid     = 1'b0;
    perm_start    = 1'b0;
    busy          = (state_r != ST_IDLE);
    done          = 1'b0;
    state_clr     = 1'b0;
    lane_idx      = 5'd0;
    absorb_en     = 1'b0;
    pad_head_en   = 1'b0;
    pad_byte      = 3'd0;
    pad_tail_en   = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (start && !rst) begin
          state_clr     = 1'b1;
          state_nx_s    = ST_ABSORB;
          word_cnt_nx_s = 5'd0;
          sq_cnt_nx_s   = 5'd0;
          out_cnt_nx_s  = {OUT_LEN_W{1'b0}};
        end else begin
          state_nx_s = ST_IDLE;
        end
      end

      ST_ABSORB: begin
        in_ready = 1'b1;
        lane_idx = word_cnt_r;
        if (in_valid) begin
          if (!in_last) begin
            absorb_en = 1'b1;
            if (word_last_s) begin
              state_nx_s    = ST_PERM;
              ret_nx_s      = ST_ABSORB;
              word_cnt_nx_s = 5'd0;
            end else begin
              word_cnt_nx_s = word_cnt_r + 5'd1;
            end
          end else if (in_bytes < 4'd8) begin
            // Short final word: head pad lands right after the data bytes.
            absorb_en   = (in_bytes != 4'd0);
            pad_head_en = 1'b1;
            pad_byte    = in_bytes[2:0];
            if (word_last_s) begin
              pad_tail_en = 1'b1;
              state_nx_s  = ST_PERM;
              ret_nx_s    = ST_SQUEEZE;
            end else begin
              state_nx_s = ST_TAIL;
            end
          end else begin
            // Full final word: head pad goes into byte 0 of the next lane,
            // which may be in the next block.
            absorb_en = 1'b1;
            if (word_last_s) begin
              state_nx_s    = ST_PERM;
              ret_nx_s      = ST_HEAD;
              word_cnt_nx_s = 5'd0;
            end else begin
              word_cnt_nx_s = word_cnt_r + 5'd1;
              state_nx_s    = ST_HEAD;
            end
          end
        end else begin
          state_nx_s = ST_ABSORB;
        end
      end

      ST_HEAD: begin
        pad_head_en = 1'b1;
        pad_byte    = 3'd0;
        lane_idx    = word_cnt_r;
        if (word_last_s) begin
          pad_tail_en = 1'b1;
          state_nx_s  = ST_PERM;
          ret_nx_s    = ST_SQUEEZE;
        end else begin
          state_nx_s = ST_TAIL;
        end
      end

      ST_TAIL: begin
        pad_tail_en = 1'b1;
        lane_idx    = rate_m1_s;
        state_nx_s  = ST_PERM;
        ret_nx_s    = ST_SQUEEZE;
      end

      ST_PERM: begin
        perm_start = !perm_issued_r;
        if (perm_issued_r && perm_done) begin
          state_nx_s = ret_r;
        end else begin
          state_nx_s = ST_PERM;
        end
      end

      ST_SQUEEZE: begin
        if (out_len_r == {OUT_LEN_W{1'b0}}) begin
          state_nx_s = ST_DONE;
        end else begin
          out_valid = 1'b1;
          lane_idx  = sq_cnt_r;
          if (out_ready) begin
            if (out_last_s) begin
              state_nx_s = ST_DONE;
            end else if (sq_last_s) begin
              state_nx_s   = ST_PERM;
              ret_nx_s     = ST_SQUEEZE;
              sq_cnt_nx_s  = 5'd0;
              out_cnt_nx_s = out_cnt_r + {{(OUT_LEN_W-1){1'b0}}, 1'b1};
            end else begin
              sq_cnt_nx_s  = sq_cnt_r + 5'd1;
              out_cnt_nx_s = out_cnt_r + {{(OUT_LEN_W-1){1'b0}}, 1'b1};
            end
          end else begin
            state_nx_s = ST_SQUEEZE;
          end
        end
      end

      ST_DONE: begin
        done       = 1'b1;
        state_nx_s = ST_IDLE;
      end

`ifdef SHAKE_CTRL_ABORT_EN
      ST_ABORT_WAIT: begin
        if (perm_done) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_ABORT_WAIT;
        end
      end
`endif

      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase

`ifdef SHAKE_CTRL_ABORT_EN
    // Abort wins over any handshake in the same cycle; lane writes are
    // suppressed so a cancelled job leaves no partial pad behind.
    if (abort) begin
      case (state_r)
        ST_ABSORB, ST_HEAD, ST_TAIL, ST_SQUEEZE: begin
          state_nx_s  = ST_IDLE;
          absorb_en   = 1'b0;
          pad_head_en = 1'b0;
          pad_tail_en = 1'b0;
        end
        ST_PERM: begin
          if (perm_issued_r && perm_done) begin
            state_nx_s = ST_IDLE;
          end else begin
            state_nx_s = ST_ABORT_WAIT;
          end
        end
        default: begin
          state_nx_s = state_nx_s;
        end
      endcase
    end else begin
      state_nx_s = state_nx_s;
    end
`endif
  end

  // State, counters and job parameters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      ret_r         <= ST_IDLE;
      word_cnt_r    <= 5'd0;
      sq_cnt_r      <= 5'd0;
      out_cnt_r     <= {OUT_LEN_W{1'b0}};
      mode_r        <= 1'b0;
      out_len_r     <= {OUT_LEN_W{1'b0}};
      perm_issued_r <= 1'b0;
    end else begin
      state_r       <= state_nx_s;
      ret_r         <= ret_nx_s;
      word_cnt_r    <= word_cnt_nx_s;
      sq_cnt_r      <= sq_cnt_nx_s;
      out_cnt_r     <= out_cnt_nx_s;
      perm_issued_r <= (state_r == ST_PERM) && (state_nx_s == ST_PERM);
      if ((state_r == ST_IDLE) && start) begin
        mode_r    <= mode;
        out_len_r <= out_len;
      end else begin
        mode_r    <= mode_r;
        out_len_r <= out_len_r;
      end
    end
  end

endmodule

// File: tb/tb_shake_ctrl.sv
// tb_shake_ctrl: directed self-checking bench for shake_ctrl.
// A small responder answers each perm_start with perm_done PERM_LAT cycles
// later; a monitor counts enables, pads, permutations and output lanes.

module tb_shake_ctrl;

  localparam int PERM_LAT = 3;

  logic        clk;
  logic        rst;
  logic        start;
  logic        mode;
  logic [15:0] out_len;
  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  logic [3:0]  in_bytes;
  logic        state_clr;
  logic [4:0]  lane_idx;
  logic        absorb_en;
  logic        pad_head_en;
  logic [2:0]  pad_byte;
  logic        pad_tail_en;
  logic        perm_start;
  logic        perm_done;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;
`ifdef SHAKE_CTRL_ABORT_EN
  logic        abort;
`endif

  shake_ctrl dut (
    .clk(clk),
    .rst(rst),
`ifdef SHAKE_CTRL_ABORT_EN
    .abort(abort),
`endif
    .start(start),
    .mode(mode),
    .out_len(out_len),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_last(in_last),
    .in_bytes(in_bytes),
    .state_clr(state_clr),
    .lane_idx(lane_idx),
    .absorb_en(absorb_en),
    .pad_head_en(pad_head_en),
    .pad_byte(pad_byte),
    .pad_tail_en(pad_tail_en),
    .perm_start(perm_start),
    .perm_done(perm_done),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy(busy),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int fails = 0;

  // monitor state
  int n_perm = 0, n_absorb = 0, n_head = 0, n_tail = 0, n_both = 0;
  int n_ovalid = 0, n_out = 0, n_done = 0, n_clash = 0;
  logic [4:0] head_lane = 5'd0, tail_lane = 5'd0;
  logic [2:0] head_byte = 3'd0;
  logic [4:0] out_lanes [0:127];

  // snapshots taken at job start
  int b_perm, b_absorb, b_head, b_tail, b_both, b_ovalid, b_out, b_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (perm_start) n_perm++;
    if (absorb_en) n_absorb++;
    if (pad_head_en) begin n_head++; head_lane = lane_idx; head_byte = pad_byte; end
    if (pad_tail_en) begin n_tail++; tail_lane = lane_idx; end
    if (pad_head_en && pad_tail_en) n_both++;
    if (out_valid) n_ovalid++;
    if (out_valid && out_ready) begin out_lanes[n_out[6:0]] = lane_idx; n_out++; end
    if (done) n_done++;
    if (perm_start && (absorb_en || pad_head_en || pad_tail_en || state_clr)) n_clash++;
  end

  // permutation responder
  initial begin
    perm_done = 1'b0;
    forever begin
      @(negedge clk);
      if (perm_start) begin
        repeat (PERM_LAT) @(posedge clk);
        #1 perm_done = 1'b1;
        @(posedge clk);
        #1 perm_done = 1'b0;
      end
    end
  end

  task automatic snap();
    b_perm = n_perm; b_absorb = n_absorb; b_head = n_head; b_tail = n_tail;
    b_both = n_both; b_ovalid = n_ovalid; b_out = n_out; b_done = n_done;
  endtask

  // Start a job and feed nwords words; the last carries lastb bytes.
  task automatic launch(input logic m, input logic [15:0] olen, input int nwords,
                        input logic [3:0] lastb, input logic bstart);
    int t;
    snap();
    @(posedge clk); #1;
    start = 1'b1; mode = m; out_len = olen;
    @(negedge clk);
    check("state_clr_on_start", 32'(state_clr), 32'd1);
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < nwords; i++) begin
      in_valid = 1'b1;
      in_last  = (i == nwords - 1);
      in_bytes = (i == nwords - 1) ? lastb : 4'd8;
      start    = bstart && (i == 0);
      mode     = (bstart && (i == 0)) ? ~m : m;
      out_len  = (bstart && (i == 0)) ? 16'd5 : olen;
      @(negedge clk);
      if (i == 0) check("first_in_ready_latency", 32'(in_ready), 32'd1);
      t = 0;
      while (!in_ready && t < 100) begin @(negedge clk); t++; end
      check("in_ready_timeout", 32'(t), 32'(t < 100 ? t : 0));
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0; in_bytes = 4'd0; start = 1'b0;
    mode = m; out_len = olen;
  endtask

  // Drain outputs until done (out_ready toggled if tog), then check the pulse.
  task automatic finish_job(input logic tog);
    int t;
    t = 0;
    out_ready = tog ? 1'b0 : 1'b1;
    @(negedge clk);
    while (!done && t < 2000) begin
      @(posedge clk); #1;
      t++;
      out_ready = tog ? t[0] : 1'b1;
      @(negedge clk);
    end
    check("done_timeout", 32'(done), 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("done_one_cycle", 32'({done, busy}), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 1'b0; out_len = 16'd0;
    in_valid = 1'b0; in_last = 1'b0; in_bytes = 4'd0; out_ready = 1'b0;
`ifdef SHAKE_CTRL_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 32'({in_ready, out_valid, busy, done, state_clr, absorb_en,
                               pad_head_en, pad_tail_en, perm_start, lane_idx, pad_byte}), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);

    // 1: SHAKE128, empty message, two outputs
    launch(1'b0, 16'd2, 1, 4'd0, 1'b0);
    finish_job(1'b0);
    check("t1_absorb", 32'(n_absorb - b_absorb), 32'd0);
    check("t1_head_cnt", 32'(n_head - b_head), 32'd1);
    check("t1_head_lane", 32'(head_lane), 32'd0);
    check("t1_head_byte", 32'(head_byte), 32'd0);
    check("t1_tail_lane", 32'(tail_lane), 32'd20);
    check("t1_both", 32'(n_both - b_both), 32'd0);
    check("t1_perm", 32'(n_perm - b_perm), 32'd1);
    check("t1_out", 32'(n_out - b_out), 32'd2);
    check("t1_lane0", 32'(out_lanes[b_out[6:0]]), 32'd0);
    check("t1_lane1", 32'(out_lanes[7'(b_out + 1)]), 32'd1);
    check("t1_done", 32'(n_done - b_done), 32'd1);

    // 2: SHAKE256, 17 words, last with 3 bytes
    launch(1'b1, 16'd1, 17, 4'd3, 1'b0);
    finish_job(1'b0);
    check("t2_absorb", 32'(n_absorb - b_absorb), 32'd17);
    check("t2_both", 32'(n_both - b_both), 32'd1);
    check("t2_head_lane", 32'(head_lane), 32'd16);
    check("t2_head_byte", 32'(head_byte), 32'd3);
    check("t2_tail_lane", 32'(tail_lane), 32'd16);
    check("t2_perm", 32'(n_perm - b_perm), 32'd1);
    check("t2_out", 32'(n_out - b_out), 32'd1);

    // 3: SHAKE128, exactly 21 full words
    launch(1'b0, 16'd1, 21, 4'd8, 1'b0);
    finish_job(1'b0);
    check("t3_absorb", 32'(n_absorb - b_absorb), 32'd21);
    check("t3_head_lane", 32'(head_lane), 32'd0);
    check("t3_head_byte", 32'(head_byte), 32'd0);
    check("t3_tail_lane", 32'(tail_lane), 32'd20);
    check("t3_both", 32'(n_both - b_both), 32'd0);
    check("t3_perm", 32'(n_perm - b_perm), 32'd2);

    // 4: SHAKE256, 40 outputs with out_ready toggling
    launch(1'b1, 16'd40, 1, 4'd0, 1'b0);
    finish_job(1'b1);
    check("t4_out", 32'(n_out - b_out), 32'd40);
    check("t4_perm", 32'(n_perm - b_perm), 32'd3);
    check("t4_lane16", 32'(out_lanes[7'(b_out + 16)]), 32'd16);
    check("t4_lane_wrap", 32'(out_lanes[7'(b_out + 17)]), 32'd0);
    check("t4_lane_last", 32'(out_lanes[7'(b_out + 39)]), 32'd5);
    check("t4_done", 32'(n_done - b_done), 32'd1);

    // 5: out_len = 0, start pulsed while busy with other mode/out_len
    launch(1'b0, 16'd0, 1, 4'd8, 1'b1);
    finish_job(1'b0);
    check("t5_head_lane", 32'(head_lane), 32'd1);
    check("t5_tail_lane", 32'(tail_lane), 32'd20);
    check("t5_perm", 32'(n_perm - b_perm), 32'd1);
    check("t5_ovalid", 32'(n_ovalid - b_ovalid), 32'd0);
    check("t5_done", 32'(n_done - b_done), 32'd1);

    check("no_enable_with_perm_start", 32'(n_clash), 32'd0);

    // 6: reset mid-absorb
    launch(1'b0, 16'd1, 0, 4'd0, 1'b0);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("reset_mid_job", 32'({busy, in_ready}), 32'd0);

`ifdef SHAKE_CTRL_ABORT_EN
    // 7: abort during PERM waits for perm_done
    launch(1'b0, 16'd2, 1, 4'd0, 1'b0);
    begin
      int t;
      t = 0;
      @(negedge clk);
      while (!perm_start && t < 100) begin @(negedge clk); t++; end
      check("ab_perm_seen", 32'(perm_start), 32'd1);
      abort = 1'b1;
      @(posedge clk); #1 abort = 1'b0;
      @(negedge clk);
      check("ab_wait_c1", 32'(busy), 32'd1);
      @(negedge clk);
      check("ab_wait_c2", 32'(busy), 32'd1);
      @(negedge clk);
      check("ab_wait_c3", 32'(busy), 32'd1);
      @(negedge clk);
      check("ab_idle_after_done", 32'(busy), 32'd0);
      check("ab_no_done", 32'(n_done - b_done), 32'd0);
      check("ab_one_perm", 32'(n_perm - b_perm), 32'd1);
    end

    // 8: abort during SQUEEZE
    launch(1'b0, 16'd5, 1, 4'd0, 1'b0);
    begin
      int t;
      t = 0;
      out_ready = 1'b0;
      @(negedge clk);
      while (!out_valid && t < 100) begin @(negedge clk); t++; end
      check("ab_sq_valid", 32'(out_valid), 32'd1);
      abort = 1'b1;
      @(posedge clk); #1 abort = 1'b0;
      @(negedge clk);
      check("ab_sq_idle", 32'({busy, done, out_valid}), 32'd0);
      check("ab_sq_no_done", 32'(n_done - b_done), 32'd0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
